// File: rtl/uart_cmd_wrapper.sv
// Host-side UART front end: receives 8N1 bytes, packs three of them into a 24-bit command
// with a cmd_rdy/clr_cmd_rdy handshake, and serialises single-byte responses on TX.
module uart_cmd_wrapper #(
  parameter int unsigned CLKS_PER_BIT = 32,   // even, >= 8
  parameter int unsigned TIMEOUT_CLKS = 4096  // 0 disables the inter-byte timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned TmoW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // RX path state
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_fall, rx_start_det, rx_byte_vld, rx_frame_err;

  // Command assembly state
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  // TX path state
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            resp_sent_q, resp_sent_d;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Synchronise RX and track its previous value for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX deframer next state: half-bit start check, then mid-bit samples
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CntW'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_start_det = 1'b0;
    rx_byte_vld  = 1'b0;
    rx_frame_err = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d   = RxStart;
          rx_start_det = 1'b1;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // Line back high at mid start bit means it was a glitch
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d     = '0;
          rx_state_d   = RxIdle;
          rx_byte_vld  = rx_sync_q;
          rx_frame_err = ~rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX deframer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Command assembly, cmd_rdy handshake and inter-byte timeout
  always_comb begin
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    tmo_cnt_d = '0;
    if (clr_cmd_rdy || (rx_start_det && (idx_q == 2'd0))) cmd_rdy_d = 1'b0;
    if (rx_byte_vld) begin
      unique case (idx_q)
        2'd0: begin
          cmd_d[23:16] = rx_shift_q;
          idx_d        = 2'd1;
        end
        2'd1: begin
          cmd_d[15:8] = rx_shift_q;
          idx_d       = 2'd2;
        end
        2'd2: begin
          cmd_d[7:0] = rx_shift_q;
          idx_d      = 2'd0;
          cmd_rdy_d  = 1'b1;  // overrides a coincident clear
        end
        default: idx_d = 2'd0;
      endcase
    end else if (rx_frame_err) begin
      idx_d = 2'd0;
    end
    if ((TIMEOUT_CLKS != 0) && (idx_q != 2'd0) && (rx_state_q == RxIdle)) begin
      if (tmo_cnt_q == TmoLast) idx_d = 2'd0;
      else tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  // Command assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 2'd0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // TX framer next state: each bit held CLKS_PER_BIT clocks, TX is registered
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + CntW'(1);
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (send_resp) begin
          tx_shift_d = resp_data;
          tx_d       = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d    = '0;
          tx_state_d  = TxIdle;
          resp_sent_d = 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // TX framer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: stimulus pushes expected commands, TX bytes and
// resp_sent times into queues; independent monitors pop and compare.
module tb_uart_cmd_wrapper;

  localparam int CPB = 32;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rst_count = 0;
  int resp_pulses = 0;

  logic [23:0] cmd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  int          lat_exp_q[$];

  uart_cmd_wrapper #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data  (resp_data),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_count = rst_count + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Host sends one 8N1 frame; clr_cmd_rdy pulses on frame cycle clr_at (-1 = never)
  task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c < CPB) RX = 1'b0;
      else if (c < 9 * CPB) RX = b[(c - CPB) / CPB];
      else RX = stop;
      clr_cmd_rdy = (c == clr_at);
    end
    @(negedge clk);
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cmd_exp_q.push_back({b0, b1, b2});
    send_byte(b0, 1'b1, -1);
    send_byte(b1, 1'b1, -1);
    send_byte(b2, 1'b1, -1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic issue_resp(input logic [7:0] d, input bit expect_it);
    @(negedge clk);
    resp_data = d;
    send_resp = 1'b1;
    if (expect_it) begin
      tx_exp_q.push_back(d);
      lat_exp_q.push_back(cyc + 10 * CPB + 1);
    end
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  // Command monitor: every cmd_rdy rising edge consumes one expected command
  initial begin : cmd_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy && !prev) begin
        if (cmd_exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_cmd: got %06h, expected none", cmd);
        end else begin
          chk("cmd_value", 32'(cmd), 32'(cmd_exp_q.pop_front()));
        end
      end
      prev = cmd_rdy;
    end
  end

  // TX monitor: decodes frames at mid-bit; frames cut by reset are dropped
  initial begin : tx_mon
    logic [7:0] data;
    logic       stp;
    int         snap;
    forever begin
      @(negedge clk);
      if (rst_n && TX == 1'b0) begin
        snap = rst_count;
        data = 8'h00;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          data[i] = TX;
        end
        repeat (CPB) @(negedge clk);
        stp = TX;
        if (snap == rst_count) begin
          if (tx_exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_tx: got %02h, expected none", data);
          end else begin
            chk("tx_byte", 32'(data), 32'(tx_exp_q.pop_front()));
            chk("tx_stop_bit", 32'(stp), 32'd1);
          end
        end
      end
    end
  end

  // resp_sent monitor: checks arrival cycle and single-cycle width
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (resp_sent) begin
        resp_pulses++;
        if (lat_exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_resp_sent: got pulse at cycle %0d, expected none", cyc);
        end else begin
          chk("resp_sent_cycle", 32'(cyc), 32'(lat_exp_q.pop_front()));
        end
        @(negedge clk);
        chk("resp_sent_width", 32'(resp_sent), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog: got no finish, expected finish within 200000 cycles");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(TX), 32'd1);
    chk("reset_cmd", 32'(cmd), 32'd0);
    chk("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("reset_resp_sent", 32'(resp_sent), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command and clear
    send_cmd(8'h02, 8'h0C, 8'h00);
    chk("t1_cmd_rdy_set", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    chk("t1_cmd_rdy_clr", 32'(cmd_rdy), 32'd0);

    // Command followed by a response frame
    send_cmd(8'h07, 8'h00, 8'h00);
    pulse_clr();
    issue_resp(8'h04, 1'b1);
    repeat (10 * CPB + 20) @(negedge clk);

    // Partial command abandoned by timeout
    send_byte(8'h03, 1'b1, -1);
    send_byte(8'h0C, 1'b1, -1);
    repeat (TMO + 10) @(negedge clk);
    send_cmd(8'h01, 8'h00, 8'h00);
    pulse_clr();

    // Framing error on byte 2 discards the partial command
    send_byte(8'h08, 1'b1, -1);
    send_byte(8'h06, 1'b0, -1);
    repeat (CPB) @(negedge clk);
    send_cmd(8'h09, 8'h06, 8'h00);
    pulse_clr();

    // Set beats coincident clear; TX runs concurrently and ignores a mid-frame send_resp
    cmd_exp_q.push_back(24'h0A0B0C);
    fork
      begin
        send_byte(8'h0A, 1'b1, -1);
        send_byte(8'h0B, 1'b1, -1);
        send_byte(8'h0C, 1'b1, 9 * CPB + CPB / 2 + 2);
      end
      begin
        repeat (50) @(negedge clk);
        issue_resp(8'hA5, 1'b1);
        repeat (100) @(negedge clk);
        issue_resp(8'h5A, 1'b0);
      end
    join
    chk("t5_set_wins", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    repeat (10 * CPB) @(negedge clk);

    // One-clock glitch must not produce a byte
    @(negedge clk);
    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_cmd(8'h11, 8'h22, 8'h33);

    // Reset in the middle of a TX frame
    issue_resp(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    p = resp_pulses;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(TX), 32'd1);
    chk("abort_cmd", 32'(cmd), 32'd0);
    chk("abort_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("abort_resp_sent", 32'(resp_sent), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("abort_no_resp_sent", 32'(resp_pulses), 32'(p));

    // Path still works after the abort
    issue_resp(8'hC3, 1'b1);
    repeat (10 * CPB + 50) @(negedge clk);

    chk("cmd_queue_drained", 32'(cmd_exp_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    chk("lat_queue_drained", 32'(lat_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
